// File: rtl/rx78_pixel_fetch.sv
// rtl/rx78_pixel_fetch.sv - RX-78 three-plane VRAM fetch and pixel serialiser.
// Optional palette storage is enabled by defining RX78_PALETTE_EN.
module rx78_pixel_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        cen,
    input  logic [7:0]  hcount,
    input  logic [7:0]  vcount,
    input  logic        hb,
    input  logic        vb,
    output logic [14:0] vram_addr,
    input  logic [7:0]  vram_q,
    input  logic        pal_we,
    input  logic [2:0]  pal_addr,
    input  logic [5:0]  pal_din,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        fetch_err
);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP} state_t;

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [12:0] off_q, off_d;
    logic        blank_q, blank_d;
    logic [7:0]  cap0_q, cap0_d, cap1_q, cap1_d, cap2_q, cap2_d;
    logic [7:0]  hold0_q, hold0_d, hold1_q, hold1_d, hold2_q, hold2_d;
    logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [23:0] rgb_q, rgb_d;
    logic        err_q, err_d;

    logic        grp_trig, line_trig, trig;
    logic [7:0]  row_sel;
    logic [4:0]  grp_sel;
    logic [12:0] off_sel;
    logic        active;
    logic [2:0]  raw_idx, idx;
    logic [23:0] rgb_col;

    assign grp_trig  = cen && (hcount[2:0] == 3'd0) && (hcount <= 8'd176);
    assign line_trig = cen && (hcount == 8'd248);
    assign trig      = grp_trig || line_trig;
    // The line-start fetch prepares group 0 of the row about to be displayed.
    assign row_sel   = line_trig ? vcount + 8'd1 : vcount;
    assign grp_sel   = line_trig ? 5'd0 : hcount[7:3] + 5'd1;
    assign off_sel   = {5'd0, row_sel} * 13'd24 + {8'd0, grp_sel};
    assign active    = (hcount < 8'd192) && (vcount < 8'd184) && !hb && !vb;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        blank_d = blank_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        cap2_d  = cap2_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        hold2_d = hold2_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (trig) begin
                state_d = S_RD0;
                off_d   = off_sel;
                blank_d = (row_sel >= 8'd184);
                addr_d  = {2'd0, off_sel};
            end
            S_RD0: begin
                state_d = S_RD1;
                addr_d  = {2'd1, off_q};
            end
            S_RD1: begin
                state_d = S_RD2;
                cap0_d  = vram_q;
                addr_d  = {2'd2, off_q};
            end
            S_RD2: begin
                state_d = S_CAP;
                cap1_d  = vram_q;
            end
            S_CAP: begin
                state_d = S_IDLE;
                cap2_d  = vram_q;
                hold0_d = blank_q ? 8'd0 : cap0_q;
                hold1_d = blank_q ? 8'd0 : cap1_q;
                hold2_d = blank_q ? 8'd0 : vram_q;
            end
            default: state_d = S_IDLE;
        endcase
        if (trig && (state_q != S_IDLE)) err_d = 1'b1;
    end

`ifdef RX78_PALETTE_EN
    logic [5:0] pal_q [8];
    logic [5:0] ent;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                pal_q[i] <= {{2{i[0]}}, {2{i[1]}}, {2{i[2]}}};
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_din;
        end
    end

    assign ent     = pal_q[idx];
    assign rgb_col = {{4{ent[5:4]}}, {4{ent[3:2]}}, {4{ent[1:0]}}};
`else
    logic unused_pal;
    assign unused_pal = ^{pal_we, pal_addr, pal_din};
    assign rgb_col    = {{8{idx[0]}}, {8{idx[1]}}, {8{idx[2]}}};
`endif

    // Group boundary pixels come straight from the holding registers so the
    // shifters never wait on the fetch that completes mid-group.
    always_comb begin
        raw_idx = 3'd0;
        idx     = 3'd0;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        rgb_d   = rgb_q;
        if (cen) begin
            if (hcount[2:0] == 3'd0) begin
                raw_idx = {hold2_q[0], hold1_q[0], hold0_q[0]};
                sh0_d   = hold0_q >> 1;
                sh1_d   = hold1_q >> 1;
                sh2_d   = hold2_q >> 1;
            end else begin
                raw_idx = {sh2_q[0], sh1_q[0], sh0_q[0]};
                sh0_d   = sh0_q >> 1;
                sh1_d   = sh1_q >> 1;
                sh2_d   = sh2_q >> 1;
            end
            idx   = active ? raw_idx : 3'd0;
            rgb_d = rgb_col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 15'd0;
            off_q   <= 13'd0;
            blank_q <= 1'b0;
            cap0_q  <= 8'd0;
            cap1_q  <= 8'd0;
            cap2_q  <= 8'd0;
            hold0_q <= 8'd0;
            hold1_q <= 8'd0;
            hold2_q <= 8'd0;
            sh0_q   <= 8'd0;
            sh1_q   <= 8'd0;
            sh2_q   <= 8'd0;
            rgb_q   <= 24'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            blank_q <= blank_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            cap2_q  <= cap2_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            hold2_q <= hold2_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            rgb_q   <= rgb_d;
            err_q   <= err_d;
        end
    end

    assign vram_addr = addr_q;
    assign red       = rgb_q[23:16];
    assign green     = rgb_q[15:8];
    assign blue      = rgb_q[7:0];
    assign fetch_err = err_q;

endmodule

// File: tb/tb_rx78_pixel_fetch.sv
// tb/tb_rx78_pixel_fetch.sv - self-checking bench for rx78_pixel_fetch.
module tb_rx78_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset, cen, hb, vb, pal_we;
    logic [7:0]  hcount, vcount, vram_q;
    logic [14:0] vram_addr;
    logic [2:0]  pal_addr;
    logic [5:0]  pal_din;
    logic [7:0]  red, green, blue;
    logic        fetch_err;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  vram [0:32767];
    logic [5:0]  pal_m [0:7];
    logic [23:0] got [0:255];

    rx78_pixel_fetch dut (
        .clk(clk), .reset(reset), .cen(cen), .hcount(hcount), .vcount(vcount),
        .hb(hb), .vb(vb), .vram_addr(vram_addr), .vram_q(vram_q),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_din(pal_din),
        .red(red), .green(green), .blue(blue), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vram_q <= vram[vram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pal_defaults;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] ii;
            ii = 3'(i);
            pal_m[i] = {ii[0] ? 2'd3 : 2'd0, ii[1] ? 2'd3 : 2'd0, ii[2] ? 2'd3 : 2'd0};
        end
    endtask

    function automatic logic [23:0] colour(input logic [2:0] ci);
`ifdef RX78_PALETTE_EN
        logic [5:0] e;
        e = pal_m[ci];
        return {{4{e[5:4]}}, {4{e[3:2]}}, {4{e[1:0]}}};
`else
        return {ci[0] ? 8'hFF : 8'h00, ci[1] ? 8'hFF : 8'h00, ci[2] ? 8'hFF : 8'h00};
`endif
    endfunction

    // Pixel (h,v) is bit h%8 of byte v*24+h/8 in each plane.
    function automatic logic [23:0] exp_pix(input logic [7:0] h, input logic [7:0] v);
        int off, b;
        logic [2:0] ci;
        if (h >= 8'd192 || v >= 8'd184) return colour(3'd0);
        off = int'(v) * 24 + int'(h) / 8;
        b   = int'(h) % 8;
        ci  = {vram[16384 + off][b], vram[8192 + off][b], vram[off][b]};
        return colour(ci);
    endfunction

    task automatic strobe(input logic [7:0] h, input logic [7:0] v);
        hcount = h;
        vcount = v;
        hb     = (h >= 8'd192);
        vb     = (v >= 8'd184);
        cen    = 1'b1;
        tick();
        cen    = 1'b0;
    endtask

    task automatic run_line(input logic [7:0] v);
        logic [7:0] h, vc;
        for (int k = 0; k < 256; k++) begin
            h  = 8'(248 + k);
            vc = (k < 8) ? v - 8'd1 : v;
            strobe(h, vc);
            got[h] = {red, green, blue};
            chk("pixel", {8'd0, red, green, blue}, {8'd0, exp_pix(h, vc)});
            repeat (3) tick();
        end
        chk("no_fetch_err", {31'd0, fetch_err}, 32'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        pal_defaults();
    endtask

    initial begin
        reset = 1'b1; cen = 1'b0; hcount = 8'd0; vcount = 8'd0; hb = 1'b0; vb = 1'b0;
        pal_we = 1'b0; pal_addr = 3'd0; pal_din = 6'd0;
        for (int i = 0; i < 32768; i++) vram[i] = 8'd0;
        pal_defaults();
        do_reset();

        chk("reset_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("reset_err", {31'd0, fetch_err}, 32'd0);
        chk("reset_addr", {17'd0, vram_addr}, 32'd0);

        // Line-start fetch for row 10
        strobe(8'd248, 8'd9);
        chk("addr_p0", {17'd0, vram_addr}, 32'h00F0);
        tick();
        chk("addr_p1", {17'd0, vram_addr}, 32'h20F0);
        tick();
        chk("addr_p2", {17'd0, vram_addr}, 32'h40F0);
        repeat (6) tick();

        for (int r = 0; r < 4; r++)
            for (int g = 0; g < 24; g++)
                for (int p = 0; p < 3; p++)
                    vram[p * 8192 + r * 24 + g] = 8'($urandom);
        vram[0] = 8'h01; vram[8192] = 8'h02; vram[16384] = 8'h04;
        vram[2 * 24 + 23] = 8'hFF; vram[8192 + 2 * 24 + 23] = 8'hFF;
        for (int p = 0; p < 3; p++) vram[p * 8192 + 184 * 24] = 8'hFF;

        run_line(8'd0);
        chk("line0_px0", {8'd0, got[0]}, 32'hFF0000);
        chk("line0_px1", {8'd0, got[1]}, 32'h00FF00);
        chk("line0_px2", {8'd0, got[2]}, 32'h0000FF);
        for (int i = 3; i < 8; i++) chk("line0_px3_7", {8'd0, got[i]}, 32'd0);
        run_line(8'd1);
        run_line(8'd2);

        // Row 184 fetch must leave the holding registers zero
        strobe(8'd248, 8'd183);
        repeat (5) tick();
        chk("row184_hold0", {24'd0, dut.hold0_q}, 32'd0);
        chk("row184_hold1", {24'd0, dut.hold1_q}, 32'd0);
        chk("row184_hold2", {24'd0, dut.hold2_q}, 32'd0);
        chk("row184_err", {31'd0, fetch_err}, 32'd0);
        run_line(8'd184);
        for (int i = 0; i < 8; i++) chk("row184_black", {8'd0, got[i]}, 32'd0);

        // All-ones pixel, then reset during RD1 of the following fetch
        for (int p = 0; p < 3; p++) vram[p * 8192 + 24] = 8'hFF;
        strobe(8'd248, 8'd0);
        repeat (5) tick();
        pal_we = 1'b1; pal_addr = 3'd7; pal_din = 6'h24;
        tick();
        pal_we = 1'b0;
`ifdef RX78_PALETTE_EN
        pal_m[7] = 6'h24;
        strobe(8'd0, 8'd1);
        chk("palette_pixel", {8'd0, red, green, blue}, 32'hAA5500);
`else
        strobe(8'd0, 8'd1);
        chk("fixed_pixel", {8'd0, red, green, blue}, 32'hFFFFFF);
`endif
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pal_defaults();
        chk("abort_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("abort_addr", {17'd0, vram_addr}, 32'd0);
        repeat (6) tick();
        chk("abort_hold0", {24'd0, dut.hold0_q}, 32'd0);
        chk("abort_hold1", {24'd0, dut.hold1_q}, 32'd0);
        chk("abort_hold2", {24'd0, dut.hold2_q}, 32'd0);
        chk("abort_err", {31'd0, fetch_err}, 32'd0);

        // Two triggers 2 clk apart
        strobe(8'd8, 8'd1);
        tick();
        strobe(8'd16, 8'd1);
        chk("err_set", {31'd0, fetch_err}, 32'd1);
        repeat (10) tick();
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);
        strobe(8'd24, 8'd1);
        repeat (6) tick();
        chk("err_sticky2", {31'd0, fetch_err}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, fetch_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
